// File: rtl/sram_like_arbiter_pkg.sv
// Shared definitions for the sram-like bus arbiter.
//   state_t      : arbiter FSM states (IDLE / REQ / WAIT)
//   ARB_FIXED/RR : arbitration mode selectors
//   clog2_min1() : index/counter width helper that never returns 0
package sram_like_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_like_arbiter_rr_arbiter.sv
// Combinational request picker for the sram-like arbiter.
//   req   : per-channel request vector
//   ptr   : round-robin search start (ignored when mode = 0)
//   mode  : 0 = lowest index wins, 1 = first set index at or after ptr
//   grant : one-hot winner (all zero when no request)
//   idx   : binary index of the winner
module sram_like_arbiter_rr_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int IDX_W = clog2_min1(NCH)
) (
  input  logic [NCH-1:0]   req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             mode,
  output logic [NCH-1:0]   grant,
  output logic [IDX_W-1:0] idx
);

  int   start;
  int   cand;
  logic found;

  // Walk the channels once starting at the search origin, wrapping modulo NCH.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    start = (mode && NCH > 1) ? int'(ptr) : 0;
    for (int i = 0; i < NCH; i++) begin
      cand = (start + i) % NCH;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Arbitrates NCH core-side memory channels onto one sram-like bus with a
// req/addr_ok/data_ok handshake, one transaction outstanding at a time.
//   cpu_clk_50M, cpu_rst_n          : clock, async active-low reset
//   ch_req/ch_we/ch_addr/ch_wdata   : per-channel request and fields (packed)
//   ch_addr_ok, ch_data_ok          : one-cycle accept / completion pulses
//   ch_rdata                        : shared read data, valid with ch_data_ok
//   bus_req/bus_we/bus_addr/wdata   : bus request and latched fields
//   bus_addr_ok, bus_data_ok, rdata : bus responses
//   busy                            : transaction in REQ or WAIT
//   err                             : sticky timeout / stray data_ok flag
//
// state   | meaning
// IDLE    | waiting for a channel request; grant is combinational
// REQ     | bus_req high, waiting for bus_addr_ok
// WAIT    | address accepted, waiting for bus_data_ok
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int NCH      = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int ARB_MODE = ARB_FIXED,
  parameter int TIMEOUT  = 255
) (
  input  logic                      cpu_clk_50M,
  input  logic                      cpu_rst_n,
  input  logic [NCH-1:0]            ch_req,
  input  logic [NCH*(DATA_W/8)-1:0] ch_we,
  input  logic [NCH*ADDR_W-1:0]     ch_addr,
  input  logic [NCH*DATA_W-1:0]     ch_wdata,
  output logic [NCH-1:0]            ch_addr_ok,
  output logic [NCH-1:0]            ch_data_ok,
  output logic [DATA_W-1:0]         ch_rdata,
  output logic                      bus_req,
  output logic [DATA_W/8-1:0]       bus_we,
  output logic [ADDR_W-1:0]         bus_addr,
  output logic [DATA_W-1:0]         bus_wdata,
  input  logic                      bus_addr_ok,
  input  logic                      bus_data_ok,
  input  logic [DATA_W-1:0]         bus_rdata,
  output logic                      busy,
  output logic                      err
);

  localparam int   WE_W    = DATA_W / 8;
  localparam int   IDX_W   = clog2_min1(NCH);
  localparam int   CNT_W   = clog2_min1(TIMEOUT + 1);
  localparam logic RR_MODE = (ARB_MODE == ARB_RR);

  state_t           state, state_nx;
  logic [IDX_W-1:0] gnt_q, ptr_q, arb_idx;
  logic [NCH-1:0]   arb_grant, gnt_oh;
  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_hit, accept, abort;

  sram_like_arbiter_rr_arbiter #(.NCH(NCH), .IDX_W(IDX_W)) u_arb (
    .req   (ch_req),
    .ptr   (ptr_q),
    .mode  (RR_MODE),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  assign gnt_oh  = NCH'(1) << gnt_q;
  assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt == CNT_W'(TIMEOUT));
  assign busy    = (state != ST_IDLE);

  always_comb begin
    state_nx   = state;
    ch_addr_ok = '0;
    ch_data_ok = '0;
    ch_rdata   = '0;
    bus_req    = 1'b0;
    accept     = 1'b0;
    abort      = 1'b0;
    case (state)
      ST_IDLE: begin
        // Gated by reset so no channel sees an accept that the registers drop.
        if (cpu_rst_n && |ch_req) begin
          accept     = 1'b1;
          ch_addr_ok = arb_grant;
          state_nx   = ST_REQ;
        end
      end
      ST_REQ: begin
        bus_req = 1'b1;
        if (bus_addr_ok) begin
          if (bus_data_ok) begin
            ch_data_ok = gnt_oh;
            ch_rdata   = bus_rdata;
            state_nx   = ST_IDLE;
          end else begin
            state_nx = ST_WAIT;
          end
        end else if (tmo_hit) begin
          abort      = 1'b1;
          bus_req    = 1'b0;
          ch_data_ok = gnt_oh;
          state_nx   = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (bus_data_ok) begin
          ch_data_ok = gnt_oh;
          ch_rdata   = bus_rdata;
          state_nx   = ST_IDLE;
        end else if (tmo_hit) begin
          abort      = 1'b1;
          ch_data_ok = gnt_oh;
          state_nx   = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state     <= ST_IDLE;
      gnt_q     <= '0;
      ptr_q     <= '0;
      bus_we    <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      tmo_cnt   <= '0;
      err       <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        gnt_q     <= arb_idx;
        bus_we    <= ch_we[int'(arb_idx)*WE_W +: WE_W];
        bus_addr  <= ch_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
        bus_wdata <= ch_wdata[int'(arb_idx)*DATA_W +: DATA_W];
        ptr_q     <= (int'(arb_idx) == NCH - 1) ? '0 : arb_idx + 1'b1;
      end
      // Any bus progress restarts the no-response window.
      if (accept || (state == ST_REQ && bus_addr_ok)) begin
        tmo_cnt <= '0;
      end else if (state != ST_IDLE) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (abort || (state == ST_IDLE && bus_data_ok)) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
module tb_sram_like_arbiter;
  localparam int NCH = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int WW  = 4;
  localparam int TMO = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Index 0: fixed-priority instance, index 1: round-robin instance.
  logic [NCH-1:0]    ch_req[2], ch_addr_ok[2], ch_data_ok[2];
  logic [NCH*WW-1:0] ch_we[2];
  logic [NCH*AW-1:0] ch_addr[2];
  logic [NCH*DW-1:0] ch_wdata[2];
  logic [DW-1:0]     ch_rdata[2], bus_wdata[2], bus_rdata[2];
  logic              bus_req[2], bus_addr_ok[2], bus_data_ok[2], busy[2], err[2];
  logic [WW-1:0]     bus_we[2];
  logic [AW-1:0]     bus_addr[2];

  sram_like_arbiter #(.NCH(NCH), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0), .TIMEOUT(TMO)) u_fix (
    .cpu_clk_50M(clk), .cpu_rst_n(rst_n),
    .ch_req(ch_req[0]), .ch_we(ch_we[0]), .ch_addr(ch_addr[0]), .ch_wdata(ch_wdata[0]),
    .ch_addr_ok(ch_addr_ok[0]), .ch_data_ok(ch_data_ok[0]), .ch_rdata(ch_rdata[0]),
    .bus_req(bus_req[0]), .bus_we(bus_we[0]), .bus_addr(bus_addr[0]), .bus_wdata(bus_wdata[0]),
    .bus_addr_ok(bus_addr_ok[0]), .bus_data_ok(bus_data_ok[0]), .bus_rdata(bus_rdata[0]),
    .busy(busy[0]), .err(err[0])
  );

  sram_like_arbiter #(.NCH(NCH), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1), .TIMEOUT(TMO)) u_rr (
    .cpu_clk_50M(clk), .cpu_rst_n(rst_n),
    .ch_req(ch_req[1]), .ch_we(ch_we[1]), .ch_addr(ch_addr[1]), .ch_wdata(ch_wdata[1]),
    .ch_addr_ok(ch_addr_ok[1]), .ch_data_ok(ch_data_ok[1]), .ch_rdata(ch_rdata[1]),
    .bus_req(bus_req[1]), .bus_we(bus_we[1]), .bus_addr(bus_addr[1]), .bus_wdata(bus_wdata[1]),
    .bus_addr_ok(bus_addr_ok[1]), .bus_data_ok(bus_data_ok[1]), .bus_rdata(bus_rdata[1]),
    .busy(busy[1]), .err(err[1])
  );

  logic [AW-1:0] m_addr[NCH];
  logic [WW-1:0] m_we[NCH];
  logic [DW-1:0] m_wdata[NCH];

  int npass  = 0;
  int ntotal = 0;
  int nfail  = 0;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int m, input int c, input logic [WW-1:0] we,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    m_we[c] = we; m_addr[c] = addr; m_wdata[c] = wdata;
    ch_we[m][c*WW +: WW]    = we;
    ch_addr[m][c*AW +: AW]  = addr;
    ch_wdata[m][c*DW +: DW] = wdata;
    ch_req[m][c] = 1'b1;
  endtask

  // Called at posedge+1 with the DUT idle and channel g expected to win.
  task automatic txn(input int m, input int g, input int d_addr, input bit same,
                     input int d_data, input logic [DW-1:0] rd);
    logic [NCH-1:0] oh;
    oh = '0; oh[g] = 1'b1;
    @(negedge clk);
    check("accept", {busy[m], ch_addr_ok[m]}, {1'b0, oh});
    @(posedge clk); #1;
    ch_req[m][g] = 1'b0;
    for (int i = 0; i < d_addr; i++) begin
      @(negedge clk);
      check("req_hold", {busy[m], bus_req[m], ch_addr_ok[m], ch_data_ok[m], bus_we[m], bus_addr[m], bus_wdata[m]},
            {1'b1, 1'b1, 2'b00, 2'b00, m_we[g], m_addr[g], m_wdata[g]});
      @(posedge clk); #1;
    end
    bus_addr_ok[m] = 1'b1;
    if (same) begin bus_data_ok[m] = 1'b1; bus_rdata[m] = rd; end
    @(negedge clk);
    check("addr_phase", {busy[m], bus_req[m], bus_we[m], bus_addr[m], bus_wdata[m]},
          {1'b1, 1'b1, m_we[g], m_addr[g], m_wdata[g]});
    if (same) check("same_cycle_done", {ch_data_ok[m], ch_rdata[m]}, {oh, rd});
    else      check("no_early_done", {30'd0, ch_data_ok[m]}, 32'd0);
    @(posedge clk); #1;
    bus_addr_ok[m] = 1'b0; bus_data_ok[m] = 1'b0;
    if (!same) begin
      for (int i = 0; i < d_data; i++) begin
        @(negedge clk);
        check("wait", {busy[m], bus_req[m], ch_data_ok[m]}, {1'b1, 1'b0, 2'b00});
        @(posedge clk); #1;
      end
      bus_data_ok[m] = 1'b1; bus_rdata[m] = rd;
      @(negedge clk);
      check("data_done", {busy[m], ch_data_ok[m], ch_rdata[m]}, {1'b1, oh, rd});
      @(posedge clk); #1;
      bus_data_ok[m] = 1'b0; bus_rdata[m] = 32'hA5A5_5A5A;
    end
  endtask

  task automatic idle_cycle(input int m);
    @(negedge clk);
    check("idle", {busy[m], bus_req[m], ch_data_ok[m]}, 4'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int m = 0; m < 2; m++) begin
      ch_req[m] = '0; bus_addr_ok[m] = 1'b0; bus_data_ok[m] = 1'b0;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", npass, ntotal);
    $fatal(1);
  end

  initial begin
    int g, ptr, c;
    bit pend[NCH];
    int rr_exp[4];
    logic [NCH-1:0] oh;
    rr_exp = '{0, 1, 0, 1};
    for (int m = 0; m < 2; m++) begin
      ch_req[m] = '0; ch_we[m] = '0; ch_addr[m] = '0; ch_wdata[m] = '0;
      bus_addr_ok[m] = 1'b0; bus_data_ok[m] = 1'b0; bus_rdata[m] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int m = 0; m < 2; m++)
      check("reset_state", {busy[m], err[m], bus_req[m], ch_addr_ok[m], ch_data_ok[m], ch_rdata[m], bus_we[m], bus_addr[m]},
            '0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single read, ch0.
    set_ch(0, 0, 4'b0000, 32'h1000, 32'h0);
    txn(0, 0, 1, 1'b0, 1, 32'hDEAD_BEEF);
    idle_cycle(0);

    // Fixed priority: ch0 first, ch1 on the following idle cycle.
    set_ch(0, 0, 4'b0000, 32'h0100, 32'h0);
    set_ch(0, 1, 4'b1111, 32'h0200, 32'hCAFE_0001);
    txn(0, 0, 0, 1'b0, 0, 32'h1111_1111);
    txn(0, 1, 0, 1'b0, 0, 32'h2222_2222);

    // Round robin with both channels held: 0,1,0,1.
    set_ch(1, 0, 4'b0000, 32'h0400, 32'h0);
    set_ch(1, 1, 4'b0000, 32'h0800, 32'h0);
    for (int k = 0; k < 4; k++) begin
      txn(1, rr_exp[k], 0, 1'b0, 0, 32'h3000_0000 + 32'(k));
      if (k < 2) set_ch(1, rr_exp[k], 4'b0000, (rr_exp[k] == 0) ? 32'h0400 : 32'h0800, 32'h0);
    end

    // Write ch1 with fields held across 3 cycles of no address accept.
    set_ch(0, 1, 4'b0011, 32'h2004, 32'h1234_5678);
    txn(0, 1, 3, 1'b0, 1, 32'h0);

    // addr_ok and data_ok together: done immediately, idle next cycle.
    set_ch(0, 0, 4'b0000, 32'h5000, 32'h0);
    txn(0, 0, 0, 1'b1, 0, 32'h0BAD_F00D);
    idle_cycle(0);

    // Timeout after TMO silent REQ cycles.
    bus_rdata[0] = 32'hFFFF_FFFF;
    set_ch(0, 0, 4'b0000, 32'h6000, 32'h0);
    @(negedge clk);
    check("tmo_accept", {30'd0, ch_addr_ok[0]}, 32'd1);
    @(posedge clk); #1;
    ch_req[0] = '0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      check("tmo_pending", {bus_req[0], ch_data_ok[0], err[0]}, {1'b1, 2'b00, 1'b0});
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("tmo_fire", {bus_req[0], ch_data_ok[0], ch_rdata[0]}, {1'b0, 2'b01, 32'd0});
    @(posedge clk); #1;
    @(negedge clk);
    check("tmo_err", {busy[0], err[0]}, 2'b01);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("err_sticky", {30'd0, err[0]}, 32'd1);
    @(posedge clk); #1;

    // Stray bus_data_ok while idle.
    do_reset();
    @(negedge clk);
    check("err_cleared", {31'd0, err[0]}, 32'd0);
    @(posedge clk); #1;
    bus_data_ok[0] = 1'b1;
    @(negedge clk);
    check("stray_no_data", {29'd0, ch_data_ok[0], err[0]}, 32'd0);
    @(posedge clk); #1;
    bus_data_ok[0] = 1'b0;
    @(negedge clk);
    check("stray_err", {31'd0, err[0]}, 32'd1);
    @(posedge clk); #1;
    do_reset();

    // Async reset while waiting for data.
    set_ch(0, 0, 4'b0000, 32'h3000, 32'h0);
    @(negedge clk);
    check("rst_accept", {30'd0, ch_addr_ok[0]}, 32'd1);
    @(posedge clk); #1;
    ch_req[0] = '0; bus_addr_ok[0] = 1'b1;
    @(negedge clk);
    check("rst_req", {31'd0, bus_req[0]}, 32'd1);
    @(posedge clk); #1;
    bus_addr_ok[0] = 1'b0;
    @(negedge clk);
    check("rst_in_wait", {busy[0], bus_req[0]}, 2'b10);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {busy[0], bus_req[0], ch_addr_ok[0], ch_data_ok[0], err[0], bus_addr[0]}, '0);
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    idle_cycle(0);
    idle_cycle(0);
    set_ch(0, 1, 4'b1000, 32'h7000, 32'h7777_0000);
    txn(0, 1, 1, 1'b0, 2, 32'h7654_3210);

    // Random traffic against the priority rules, both instances.
    for (int m = 0; m < 2; m++) begin
      do_reset();
      ptr = 0;
      for (int k = 0; k < NCH; k++) pend[k] = 1'b0;
      repeat (30) begin
        for (int k = 0; k < NCH; k++)
          if (!pend[k] && $urandom_range(0, 1) == 1) begin
            pend[k] = 1'b1;
            set_ch(m, k, 4'($urandom_range(0, 15)), $urandom, $urandom);
          end
        c = 0;
        for (int k = 0; k < NCH; k++) if (pend[k]) c++;
        if (c == 0) begin
          g = $urandom_range(0, NCH - 1);
          pend[g] = 1'b1;
          set_ch(m, g, 4'($urandom_range(0, 15)), $urandom, $urandom);
        end
        g = -1;
        for (int k = 0; k < NCH; k++) begin
          c = (m == 1) ? (ptr + k) % NCH : k;
          if (g < 0 && pend[c]) g = c;
        end
        txn(m, g, $urandom_range(0, 3), ($urandom_range(0, 3) == 0), $urandom_range(0, 3), $urandom);
        pend[g] = 1'b0;
        ptr = (g + 1) % NCH;
      end
      oh = '0;
      @(negedge clk);
      check("rand_no_err", {31'd0, err[m]}, 32'd0);
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
